// File: rtl/pe_result_serializer.sv
// Output stage of the PE datapath: buffers accumulator results in a small FIFO
// and serializes each one LSB-first onto an 8-bit bus, one byte per host acknowledge.
module pe_result_serializer #(
   parameter int ACC_W = 24,
   parameter int DEPTH = 2,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic [ACC_W-1:0] res_data,
   input  logic             res_valid,
   output logic             res_ready,
   output logic [7:0]       out_byte,
   output logic             out_valid,
   output logic             out_first,
   output logic             out_last,
   input  logic             out_ack,
   output logic [CNT_W-1:0] res_count
);
   localparam int NBYTES = ACC_W / 8;
   localparam int PTR_W  = $clog2(DEPTH);
   localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [PTR_W:0]   OCC_FULL = (PTR_W + 1)'(DEPTH);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

   typedef enum logic {IDLE, SEND} state_t;

   state_t           state, state_nxt;
   logic [ACC_W-1:0] fifo_mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [PTR_W:0]   occ;
   logic [ACC_W-1:0] shreg;
   logic [IDX_W-1:0] byte_idx, idx_nxt;
   logic             fifo_empty, fifo_full;
   logic             push, pop, shift, done;

   // Occupancy has one extra bit so that full and empty never alias.
   assign fifo_empty = (occ == '0);
   assign fifo_full  = (occ == OCC_FULL);
   assign res_ready  = !fifo_full;
   assign push       = ena & res_valid & res_ready;
   assign out_byte   = shreg[7:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // A pop happens either from IDLE or straight after the last byte, which
   // lets consecutive results stream without a bubble.
   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      shift     = 1'b0;
      done      = 1'b0;
      if (ena) begin
         case (state)
            IDLE: begin
               if (!fifo_empty) begin
                  pop       = 1'b1;
                  state_nxt = SEND;
               end
            end
            SEND: begin
               if (out_ack) begin
                  if (byte_idx == LAST_IDX) begin
                     done = 1'b1;
                     if (!fifo_empty) begin
                        pop = 1'b1;
                     end else begin
                        state_nxt = IDLE;
                     end
                  end else begin
                     shift = 1'b1;
                  end
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_comb begin
      idx_nxt = byte_idx;
      if (pop) begin
         idx_nxt = '0;
      end else if (shift) begin
         idx_nxt = byte_idx + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr] <= res_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   occ <= occ + 1'b1;
            2'b01:   occ <= occ - 1'b1;
            default: occ <= occ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shreg     <= '0;
         byte_idx  <= '0;
         res_count <= '0;
         out_valid <= 1'b0;
         out_first <= 1'b0;
         out_last  <= 1'b0;
      end else if (ena) begin
         if (pop) begin
            shreg <= fifo_mem[rd_ptr];
         end else if (shift) begin
            shreg <= shreg >> 8;
         end
         byte_idx <= idx_nxt;
         if (done) begin
            res_count <= res_count + 1'b1;
         end
         out_valid <= (state_nxt == SEND);
         out_first <= (state_nxt == SEND) && (idx_nxt == '0);
         out_last  <= (state_nxt == SEND) && (idx_nxt == LAST_IDX);
      end
   end

endmodule

// File: tb/tb_pe_result_serializer.sv
// Scoreboard bench for pe_result_serializer: expected bytes are queued as results
// are driven and popped as the serializer presents them.
module tb_pe_result_serializer;
   localparam int ACC_W  = 24;
   localparam int DEPTH  = 2;
   localparam int CNT_W  = 8;
   localparam int NBYTES = ACC_W / 8;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             ena;
   logic [ACC_W-1:0] res_data;
   logic             res_valid;
   logic             res_ready;
   logic [7:0]       out_byte;
   logic             out_valid;
   logic             out_first;
   logic             out_last;
   logic             out_ack;
   logic [CNT_W-1:0] res_count;

   int         n_cmp  = 0;
   int         n_fail = 0;
   logic [9:0] exp_q[$];

   always #5 clk = ~clk;

   pe_result_serializer #(.ACC_W(ACC_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena),
      .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
      .out_byte(out_byte), .out_valid(out_valid), .out_first(out_first),
      .out_last(out_last), .out_ack(out_ack), .res_count(res_count)
   );

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic applyStimulus(input logic v, input logic [ACC_W-1:0] d, input logic ack);
      res_valid = v;
      res_data  = d;
      out_ack   = ack;
   endtask

   // Each entry is {byte, first, last}.
   function automatic void expect_result(input logic [ACC_W-1:0] d);
      for (int b = 0; b < NBYTES; b++) begin
         exp_q.push_back({d[8*b +: 8], (b == 0), (b == NBYTES - 1)});
      end
   endfunction

   task automatic do_reset();
      ena   = 1'b1;
      rst_n = 1'b0;
      applyStimulus(1'b0, '0, 1'b0);
      exp_q.delete();
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      ena   = 1'b1;
      rst_n = 1'b0;
      applyStimulus(1'b0, '0, 1'b0);
      step();
      n_cmp++;
      if ({out_byte, out_valid, out_first, out_last, res_count} !== '0) begin
         n_fail++;
         $display("[TB] FAIL reset_outputs got byte=%h v=%b f=%b l=%b cnt=%0d expected all 0",
                  out_byte, out_valid, out_first, out_last, res_count);
      end
      rst_n = 1'b1;
      step();
      n_cmp++;
      if (res_ready !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL reset_ready got %b expected 1", res_ready);
      end
      n_cmp++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL reset_idle got out_valid=%b expected 0", out_valid);
      end
   endtask

   task automatic test_single();
      logic [9:0] e;
      do_reset();
      applyStimulus(1'b1, 24'h123456, 1'b1);
      expect_result(24'h123456);
      step();
      applyStimulus(1'b0, '0, 1'b1);
      n_cmp++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL single_early got out_valid=%b expected 0", out_valid);
      end
      step();
      for (int c = 0; c < 8 && exp_q.size() > 0; c++) begin
         n_cmp++;
         if (out_valid !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL single_valid got out_valid=%b expected 1", out_valid);
         end else begin
            e = exp_q.pop_front();
            if ({out_byte, out_first, out_last} !== e) begin
               n_fail++;
               $display("[TB] FAIL single_byte got %h/%b/%b expected %h/%b/%b",
                        out_byte, out_first, out_last, e[9:2], e[1], e[0]);
            end
         end
         step();
      end
      n_cmp++;
      if (exp_q.size() != 0 || out_valid !== 1'b0 || res_count !== 8'd1) begin
         n_fail++;
         $display("[TB] FAIL single_end got left=%0d out_valid=%b cnt=%0d expected 0/0/1",
                  exp_q.size(), out_valid, res_count);
      end
   endtask

   task automatic test_back_to_back();
      logic [9:0] e;
      do_reset();
      applyStimulus(1'b1, 24'hAABBCC, 1'b1);
      expect_result(24'hAABBCC);
      step();
      applyStimulus(1'b1, 24'h010203, 1'b1);
      expect_result(24'h010203);
      step();
      applyStimulus(1'b0, '0, 1'b1);
      for (int c = 0; c < 12 && exp_q.size() > 0; c++) begin
         n_cmp++;
         if (out_valid !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL b2b_bubble got out_valid=%b expected 1", out_valid);
         end else begin
            e = exp_q.pop_front();
            if ({out_byte, out_first, out_last} !== e) begin
               n_fail++;
               $display("[TB] FAIL b2b_byte got %h/%b/%b expected %h/%b/%b",
                        out_byte, out_first, out_last, e[9:2], e[1], e[0]);
            end
         end
         step();
      end
      n_cmp++;
      if (exp_q.size() != 0 || out_valid !== 1'b0 || res_count !== 8'd2) begin
         n_fail++;
         $display("[TB] FAIL b2b_end got left=%0d out_valid=%b cnt=%0d expected 0/0/2",
                  exp_q.size(), out_valid, res_count);
      end
   endtask

   task automatic test_backpressure();
      logic [9:0]       e;
      logic [ACC_W-1:0] vals [4] = '{24'h111213, 24'h212223, 24'h313233, 24'h414243};
      logic             rdy_exp [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
      do_reset();
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (res_ready !== rdy_exp[i]) begin
            n_fail++;
            $display("[TB] FAIL bp_ready_offer%0d got %b expected %b", i, res_ready, rdy_exp[i]);
         end
         if (rdy_exp[i]) begin
            expect_result(vals[i]);
         end
         applyStimulus(1'b1, vals[i], 1'b0);
         step();
      end
      applyStimulus(1'b0, '0, 1'b0);
      for (int p = 0; p < 3; p++) begin
         e = exp_q.pop_front();
         n_cmp++;
         if (out_valid !== 1'b1 || {out_byte, out_first, out_last} !== e) begin
            n_fail++;
            $display("[TB] FAIL bp_pulse_byte got v=%b %h/%b/%b expected v=1 %h/%b/%b",
                     out_valid, out_byte, out_first, out_last, e[9:2], e[1], e[0]);
         end
         out_ack = 1'b1;
         step();
         out_ack = 1'b0;
         step();
         n_cmp++;
         if (res_ready !== (p == 2)) begin
            n_fail++;
            $display("[TB] FAIL bp_ready_pulse%0d got %b expected %b", p, res_ready, (p == 2));
         end
      end
      out_ack = 1'b1;
      for (int c = 0; c < 12 && exp_q.size() > 0; c++) begin
         n_cmp++;
         if (out_valid !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL bp_drain_valid got out_valid=%b expected 1", out_valid);
         end else begin
            e = exp_q.pop_front();
            if ({out_byte, out_first, out_last} !== e) begin
               n_fail++;
               $display("[TB] FAIL bp_drain_byte got %h/%b/%b expected %h/%b/%b",
                        out_byte, out_first, out_last, e[9:2], e[1], e[0]);
            end
         end
         step();
      end
      n_cmp++;
      if (exp_q.size() != 0 || out_valid !== 1'b0 || res_count !== 8'd3) begin
         n_fail++;
         $display("[TB] FAIL bp_end got left=%0d out_valid=%b cnt=%0d expected 0/0/3",
                  exp_q.size(), out_valid, res_count);
      end
   endtask

   task automatic test_ena_freeze();
      logic [9:0] e;
      do_reset();
      applyStimulus(1'b1, 24'h778899, 1'b1);
      expect_result(24'h778899);
      step();
      applyStimulus(1'b0, '0, 1'b1);
      step();
      e = exp_q.pop_front();
      n_cmp++;
      if (out_valid !== 1'b1 || {out_byte, out_first, out_last} !== e) begin
         n_fail++;
         $display("[TB] FAIL freeze_byte0 got v=%b %h expected v=1 %h", out_valid, out_byte, e[9:2]);
      end
      step();
      ena = 1'b0;
      applyStimulus(1'b1, 24'hDEAD01, 1'b1);
      for (int c = 0; c < 5; c++) begin
         step();
         n_cmp++;
         if (out_valid !== 1'b1 || {out_byte, out_first, out_last} !== exp_q[0] || res_count !== 8'd0) begin
            n_fail++;
            $display("[TB] FAIL freeze_hold got v=%b %h/%b/%b cnt=%0d expected v=1 %h/%b/%b cnt=0",
                     out_valid, out_byte, out_first, out_last, res_count,
                     exp_q[0][9:2], exp_q[0][1], exp_q[0][0]);
         end
      end
      ena = 1'b1;
      applyStimulus(1'b0, '0, 1'b1);
      for (int c = 0; c < 8 && exp_q.size() > 0; c++) begin
         n_cmp++;
         if (out_valid !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL freeze_resume_valid got out_valid=%b expected 1", out_valid);
         end else begin
            e = exp_q.pop_front();
            if ({out_byte, out_first, out_last} !== e) begin
               n_fail++;
               $display("[TB] FAIL freeze_resume_byte got %h/%b/%b expected %h/%b/%b",
                        out_byte, out_first, out_last, e[9:2], e[1], e[0]);
            end
         end
         step();
      end
      for (int c = 0; c < 4; c++) begin
         n_cmp++;
         if (out_valid !== 1'b0 || res_count !== 8'd1) begin
            n_fail++;
            $display("[TB] FAIL freeze_after got out_valid=%b cnt=%0d expected 0/1", out_valid, res_count);
         end
         step();
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      applyStimulus(1'b1, 24'h445566, 1'b0);
      step();
      applyStimulus(1'b1, 24'h0A0B0C, 1'b0);
      step();
      applyStimulus(1'b1, 24'h0D0E0F, 1'b0);
      step();
      applyStimulus(1'b0, '0, 1'b1);
      step();
      n_cmp++;
      if (out_valid !== 1'b1 || out_byte !== 8'h55 || res_ready !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL midrst_setup got v=%b byte=%h rdy=%b expected 1/55/0",
                  out_valid, out_byte, res_ready);
      end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({out_byte, out_valid, out_first, out_last, res_count} !== '0 || res_ready !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL midrst_async got byte=%h v=%b f=%b l=%b cnt=%0d rdy=%b expected 0s rdy=1",
                  out_byte, out_valid, out_first, out_last, res_count, res_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 8; c++) begin
         step();
         n_cmp++;
         if (out_valid !== 1'b0 || res_count !== 8'd0) begin
            n_fail++;
            $display("[TB] FAIL midrst_after got out_valid=%b cnt=%0d expected 0/0", out_valid, res_count);
         end
      end
   endtask

   task automatic test_count_wrap();
      logic [CNT_W-1:0] exp_cnt;
      int               c;
      do_reset();
      exp_cnt = '0;
      for (int i = 0; i < 256; i++) begin
         applyStimulus(1'b1, ACC_W'($urandom), 1'b1);
         step();
         applyStimulus(1'b0, '0, 1'b1);
         c = 0;
         while (!(out_valid === 1'b1 && out_last === 1'b1) && c < 10) begin
            step();
            c++;
         end
         if (c == 10) begin
            n_cmp++;
            n_fail++;
            $display("[TB] FAIL wrap_timeout result %0d got no last byte expected within 10 cycles", i);
            break;
         end
         step();
         exp_cnt = exp_cnt + 1'b1;
         n_cmp++;
         if (res_count !== exp_cnt) begin
            n_fail++;
            $display("[TB] FAIL wrap_count result %0d got %0d expected %0d", i, res_count, exp_cnt);
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      ena   = 1'b1;
      applyStimulus(1'b0, '0, 1'b0);
      test_reset();
      test_single();
      test_back_to_back();
      test_backpressure();
      test_ena_freeze();
      test_reset_mid();
      test_count_wrap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
